// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: 2^ADDR_W x DATA_W memory, wrap-bit pointers, occupancy count,
// full/empty, programmable almost-full/almost-empty and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int AF_LEVEL = (1 << ADDR_W) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] AF_THR  = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_THR  = (ADDR_W + 1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              wr_accept;
  logic              rd_accept;

  // Status is derived purely from the registered pointers, so no input reaches an output.
  always_comb begin
    count        = wr_ptr - rd_ptr;
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    almost_full  = (count >= AF_THR);
    almost_empty = (count <= AE_THR);
    wr_accept    = wr_en && !full && !clr;
    rd_accept    = rd_en && !empty && !clr;
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // A flush leaves rd_data holding the last word; only reset zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) rd_data <= mem[rd_ptr[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH 16) against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ovf;
  logic          m_udf;

  sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Drives one cycle, advances the model on the edge, returns 1 time unit after it.
  task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
    bit was_full;
    bit was_empty;
    wr_en = w;
    rd_en = r;
    wr_data = d;
    clr = c;
    @(posedge clk);
    was_full = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (c) begin
      q.delete();
      m_valid = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_valid = r && !was_empty;
      if (m_valid) m_data = q.pop_front();
      if (w && !was_full) q.push_back(d);
      if (w && was_full) m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    model_reset();
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_full_empty: got full=%b empty=%b expected full=0 empty=1", full, empty); end
    checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost: got af=%b ae=%b expected af=0 ae=1", almost_full, almost_empty); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL reset_rd: got valid=%b data=%h expected valid=0 data=00", rd_valid, rd_data); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got ovf=%b udf=%b expected 0 0", overflow, underflow); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, DW'(i), 1'b0);
      checks++; if (count !== (AW+1)'(i)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count, i); end
      checks++; if (full !== (i == DEPTH) || almost_full !== (i >= AF) || almost_empty !== (i <= AE)) begin
        errors++; $display("FAIL fill_flags[%0d]: got full=%b af=%b ae=%b expected full=%b af=%b ae=%b", i, full, almost_full, almost_empty, i == DEPTH, i >= AF, i <= AE);
      end
    end
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      checks++; if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin errors++; $display("FAIL drain_data[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, rd_valid, rd_data, DW'(i)); end
    end
    checks++; if (empty !== 1'b1 || count !== '0) begin errors++; $display("FAIL drain_empty: got empty=%b count=%0d expected 1 0", empty, count); end
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 8'hA9)), 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    checks++; if (overflow !== 1'b1 || count !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL overflow: got ovf=%b count=%0d expected 1 16", overflow, count); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      checks++; if (rd_data !== m_data || rd_data === 8'hAA) begin errors++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, rd_data, m_data); end
    end
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== m_data) begin
      errors++; $display("FAIL underflow: got udf=%b valid=%b data=%h expected 1 0 %h", underflow, rd_valid, rd_data, m_data);
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    step(1'b0, 1'b0, '0, 1'b1);
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL clr_err: got ovf=%b udf=%b expected 0 0", overflow, underflow); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] head;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'($urandom), 1'b0);
    head = q[0];
    step(1'b1, 1'b1, 8'h77, 1'b0);
    checks++; if (rd_valid !== 1'b1 || rd_data !== head) begin errors++; $display("FAIL full_wr_rd_data: got valid=%b data=%h expected 1 %h", rd_valid, rd_data, head); end
    checks++; if (count !== 5'd15 || overflow !== 1'b1) begin errors++; $display("FAIL full_wr_rd_state: got count=%0d ovf=%b expected 15 1", count, overflow); end
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      checks++; if (rd_data !== m_data) begin errors++; $display("FAIL full_wr_rd_drain[%0d]: got %h expected %h", i, rd_data, m_data); end
    end
    step(1'b1, 1'b1, 8'h55, 1'b0);
    checks++; if (count !== 5'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL empty_wr_rd: got count=%0d udf=%b valid=%b expected 1 1 0", count, underflow, rd_valid);
    end
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (rd_data !== 8'h55 || rd_valid !== 1'b1) begin errors++; $display("FAIL empty_wr_rd_next: got valid=%b data=%h expected 1 55", rd_valid, rd_data); end
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_wrap();
    logic [DW-1:0] sent[$];
    logic [DW-1:0] d;
    for (int i = 0; i < 3; i++) begin
      d = DW'($urandom);
      sent.push_back(d);
      step(1'b1, 1'b0, d, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      d = DW'($urandom);
      sent.push_back(d);
      step(1'b1, 1'b1, d, 1'b0);
      checks++; if (count !== 5'd3 || rd_valid !== 1'b1 || rd_data !== sent[i]) begin
        errors++; $display("FAIL wrap[%0d]: got count=%0d valid=%b data=%h expected 3 1 %h", i, count, rd_valid, rd_data, sent[i]);
      end
    end
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_clear_and_reset();
    step(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom), 1'b0);
    step(1'b1, 1'b0, 8'hEE, 1'b1);
    checks++; if (count !== '0 || empty !== 1'b1 || underflow !== 1'b0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL clr: got count=%0d empty=%b udf=%b ovf=%b valid=%b expected 0 1 0 0 0", count, empty, underflow, overflow, rd_valid);
    end
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    checks++; if (rd_data !== 8'h3C || rd_valid !== 1'b1) begin errors++; $display("FAIL clr_next: got valid=%b data=%h expected 1 3c", rd_valid, rd_data); end
    for (int i = 0; i < 6; i++) step(1'b1, i[0], DW'($urandom), 1'b0);
    step(1'b1, 1'b1, DW'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      errors++; $display("FAIL async_reset_flags: got count=%0d empty=%b full=%b ae=%b af=%b expected 0 1 0 1 0", count, empty, full, almost_empty, almost_full);
    end
    checks++; if (rd_data !== '0 || rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL async_reset_rd: got data=%h valid=%b ovf=%b udf=%b expected 00 0 0 0", rd_data, rd_valid, overflow, underflow);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit w;
    bit r;
    bit c;
    int wp;
    for (int i = 0; i < 600; i++) begin
      wp = ((i / 75) % 2 == 0) ? 80 : 25;
      w = ($urandom_range(0, 99) < wp);
      r = ($urandom_range(0, 99) < (100 - wp));
      c = ($urandom_range(0, 99) == 0);
      step(w, r, DW'($urandom), c);
      checks++; if (count !== (AW+1)'(q.size())) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, count, q.size()); end
      checks++; if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
        errors++; $display("FAIL rand_full_empty[%0d]: got full=%b empty=%b expected %b %b", i, full, empty, q.size() == DEPTH, q.size() == 0);
      end
      checks++; if (almost_full !== (q.size() >= AF) || almost_empty !== (q.size() <= AE)) begin
        errors++; $display("FAIL rand_almost[%0d]: got af=%b ae=%b expected %b %b", i, almost_full, almost_empty, q.size() >= AF, q.size() <= AE);
      end
      checks++; if (rd_valid !== m_valid || rd_data !== m_data) begin
        errors++; $display("FAIL rand_rd[%0d]: got valid=%b data=%h expected %b %h", i, rd_valid, rd_data, m_valid, m_data);
      end
      checks++; if (overflow !== m_ovf || underflow !== m_udf) begin
        errors++; $display("FAIL rand_err[%0d]: got ovf=%b udf=%b expected %b %b", i, overflow, underflow, m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_simultaneous();
    test_wrap();
    test_clear_and_reset();
    idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
